// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, HALT encoding, FSM states and FIFO entry type for the fetch unit
package fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int INSTR_W = 15;
  localparam logic [INSTR_W-1:0] HALT_INSTR = 15'h7FFF;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: 2-entry prefetch FIFO with push, pop and flush (flush first, then push in the same cycle)
//   clk, rst_n : clock, synchronous active-low reset
//   push, din  : write din at the tail
//   pop        : drop the head (caller guarantees non-empty)
//   flush      : discard all entries; a simultaneous push becomes the sole entry
//   head, count: head entry (registered) and occupancy 0..2
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);
  fetch_entry_t tail;
  logic [1:0] wr_pos;
  // slot the incoming word lands in once this cycle's pop has shifted the queue
  assign wr_pos = count - {1'b0, pop};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      count <= {1'b0, push};
      if (push) head <= din;
    end else begin
      if (pop) head <= tail;
      if (push) begin
        if (wr_pos == 2'd0) head <= din;
        else tail <= din;
      end
      count <= wr_pos + {1'b0, push};
    end
  end
endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch sequencer with 2-entry prefetch, jump redirect and HALT handling
//   clk, rst_n          : clock, synchronous active-low reset
//   imem_addr/imem_data : combinational instruction memory port
//   instr, instr_pc     : FIFO head word and its address; instr_valid/instr_ready handshake
//   jump_valid/target   : one-cycle redirect, flushes the FIFO
//   resume              : leave HALTED; halt is the registered halted flag
//   Optional FETCH_PERF_EN adds fetch_count (decode handshakes) and flush_count (jumps that discarded entries)
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               resume,
  output logic               halt
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]        fetch_count,
  output logic [7:0]         flush_count
`endif
);
  state_t state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [1:0] count;
  logic pop, fetch_en;
  fetch_entry_t head, din;
  assign imem_addr = !rst_n ? RESET_PC : jump_valid ? jump_target : fetch_pc;
  assign instr_valid = rst_n && count != 2'd0;
  assign instr = rst_n ? head.instr : '0;
  assign instr_pc = rst_n ? head.pc : '0;
  assign pop = instr_valid && instr_ready;
  // a jump always fetches its target, whatever state the FSM is in
  assign fetch_en = jump_valid || (state == RUN && (count != 2'd2 || pop));
  assign din = '{pc: imem_addr, instr: imem_data};
  fetch_fifo2 u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fetch_en),
    .pop  (pop),
    .flush(jump_valid),
    .din  (din),
    .head (head),
    .count(count)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      fetch_pc <= RESET_PC;
      halt <= 1'b0;
    end else begin
      if (fetch_en) fetch_pc <= imem_addr + 1'b1;
      if (fetch_en && imem_data == HALT_INSTR) begin
        state <= DRAIN;
        halt <= 1'b0;
      end else if (jump_valid) begin
        state <= RUN;
        halt <= 1'b0;
      end else if (state == DRAIN && count == {1'b0, pop}) begin
        // FIFO empties at this edge: the HALT word has gone to decode
        state <= HALTED;
        halt <= 1'b1;
      end else if (state == HALTED && resume) begin
        state <= RUN;
        halt <= 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (pop && fetch_count != '1) fetch_count <= fetch_count + 1'b1;
      // entries consumed by a same-cycle handshake do not count as discarded
      if (jump_valid && count > {1'b0, pop} && flush_count != '1) flush_count <= flush_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: vector table, directed HALT/wrap sequences and randomized run against a queue model
module tb_fetch_controller;
  import fetch_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] imem_addr, instr_pc, jump_target;
  logic [14:0] imem_data, instr;
  logic instr_valid, instr_ready, jump_valid, resume, halt;
`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count;
  logic [7:0] flush_count;
`endif
  logic [14:0] mem [256];
  assign imem_data = mem[imem_addr];
  always #5 clk = ~clk;
  fetch_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump_valid (jump_valid),
    .jump_target(jump_target),
    .resume     (resume),
    .halt       (halt)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count(fetch_count),
    .flush_count(flush_count)
`endif
  );
  int checks = 0;
  int errors = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic drive(input logic r, input logic rdy, input logic jv, input logic [7:0] jt, input logic res);
    rst_n = r;
    instr_ready = rdy;
    jump_valid = jv;
    jump_target = jt;
    resume = res;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  typedef struct packed {
    logic rst;
    logic rdy;
    logic jv;
    logic v;
    logic [14:0] ins;
    logic [7:0] pc;
    logic [7:0] addr;
  } vec_t;
  function automatic vec_t mk(input int rst, input int rdy, input int jv, input int v, input int ins, input int pc, input int addr);
    mk.rst = rst[0];
    mk.rdy = rdy[0];
    mk.jv = jv[0];
    mk.v = v[0];
    mk.ins = ins[14:0];
    mk.pc = pc[7:0];
    mk.addr = addr[7:0];
  endfunction
  typedef struct packed {
    logic [7:0] pc;
    logic [14:0] ins;
  } ent_t;
  vec_t tv[21];
  ent_t q[$];
  logic [7:0] mpc, jt;
  logic rdy, jv, res, mhalted, mdrain, mhalt, found;
  int fcnt, flcnt;
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 15'(i + 1);
    mem[8'h40] = 15'h123;
    mem[8'h41] = 15'h055;
    tv[0] = mk(0, 0, 0, 0, 0, 0, 0);
    tv[1] = mk(0, 0, 0, 0, 0, 0, 0);
    tv[2] = mk(1, 1, 0, 0, 0, 0, 0);
    tv[3] = mk(1, 1, 0, 1, 1, 0, 1);
    tv[4] = mk(1, 1, 0, 1, 2, 1, 2);
    tv[5] = mk(1, 1, 0, 1, 3, 2, 3);
    tv[6] = mk(1, 1, 0, 1, 4, 3, 4);
    tv[7] = mk(1, 0, 0, 1, 5, 4, 5);
    tv[8] = mk(0, 0, 0, 0, 0, 0, 0);
    tv[9] = mk(1, 0, 0, 0, 0, 0, 0);
    tv[10] = mk(1, 0, 0, 1, 1, 0, 1);
    tv[11] = mk(1, 0, 0, 1, 1, 0, 2);
    tv[12] = mk(1, 0, 0, 1, 1, 0, 2);
    tv[13] = mk(1, 0, 0, 1, 1, 0, 2);
    tv[14] = mk(1, 1, 0, 1, 1, 0, 2);
    tv[15] = mk(1, 1, 0, 1, 2, 1, 3);
    tv[16] = mk(1, 1, 0, 1, 3, 2, 4);
    tv[17] = mk(1, 0, 0, 1, 4, 3, 5);
    tv[18] = mk(1, 0, 1, 1, 4, 3, 8'h40);
    tv[19] = mk(1, 1, 0, 1, 15'h123, 8'h40, 8'h41);
    tv[20] = mk(1, 1, 0, 1, 15'h055, 8'h41, 8'h42);
    for (int i = 0; i < 21; i++) begin
      drive(tv[i].rst, tv[i].rdy, tv[i].jv, 8'h40, 1'b0);
      @(negedge clk);
      if (i != 0) begin
        check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tv[i].v));
        check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(tv[i].addr));
        check($sformatf("vec%0d_halt", i), 32'(halt), 32'(1'b0));
        if (tv[i].v || !tv[i].rst) begin
          check($sformatf("vec%0d_instr", i), 32'(instr), 32'(tv[i].ins));
          check($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(tv[i].pc));
        end
`ifdef FETCH_PERF_EN
        if (i == 9) check("perf_after_reset", 32'(fetch_count), 32'(0));
`endif
      end
      tick();
    end
    mem[5] = HALT_INSTR;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 8'd5) found = 1'b1;
      else tick();
    end
    check("halt_word_seen", 32'(found), 32'(1'b1));
    check("halt_word", 32'(instr), 32'(HALT_INSTR));
    for (int n = 0; n < 3; n++) begin
      tick();
      @(negedge clk);
      check("halted_flag", 32'(halt), 32'(1'b1));
      check("halted_valid", 32'(instr_valid), 32'(1'b0));
      check("halted_addr", 32'(imem_addr), 32'(8'd6));
    end
    mem[5] = 15'd6;
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    @(negedge clk);
    check("resume_halt_clear", 32'(halt), 32'(1'b0));
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      tick();
      @(negedge clk);
      found = instr_valid;
    end
    check("resume_seen", 32'(found), 32'(1'b1));
    check("resume_pc", 32'(instr_pc), 32'(8'd6));
    tick();
    jump_valid = 1'b1;
    jump_target = 8'hFE;
    tick();
    jump_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("wrap%0d_valid", k), 32'(instr_valid), 32'(1'b1));
      check($sformatf("wrap%0d_pc", k), 32'(instr_pc), 32'(8'(8'hFE + k)));
      tick();
    end
    for (int i = 0; i < 256; i++) mem[i] = ($urandom % 16 == 0) ? HALT_INSTR : 15'($urandom);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    q.delete();
    mpc = 8'h00;
    mhalted = 1'b0;
    mdrain = 1'b0;
    mhalt = 1'b0;
    fcnt = 0;
    flcnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom % 4) != 0;
      jv = ($urandom % 20) == 0;
      jt = 8'($urandom);
      res = ($urandom % 3) == 0;
      drive(1'b1, rdy, jv, jt, res);
      @(negedge clk);
      check("rnd_valid", 32'(instr_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check("rnd_instr", 32'(instr), 32'(q[0].ins));
        check("rnd_pc", 32'(instr_pc), 32'(q[0].pc));
      end
      check("rnd_halt", 32'(halt), 32'(mhalt));
      check("rnd_addr", 32'(imem_addr), 32'(jv ? jt : mpc));
`ifdef FETCH_PERF_EN
      check("rnd_fetch_count", 32'(fetch_count), 32'(fcnt));
      check("rnd_flush_count", 32'(flush_count), 32'(flcnt));
`endif
      if (q.size() != 0 && rdy) begin
        void'(q.pop_front());
        if (fcnt < 65535) fcnt++;
      end
      if (jv) begin
        if (q.size() != 0 && flcnt < 255) flcnt++;
        q.delete();
        q.push_back('{pc: jt, ins: mem[jt]});
        mdrain = mem[jt] == HALT_INSTR;
        mpc = jt + 8'd1;
        mhalted = 1'b0;
        mhalt = 1'b0;
      end else if (mhalted) begin
        if (res) begin
          mhalted = 1'b0;
          mhalt = 1'b0;
        end
      end else if (mdrain) begin
        if (q.size() == 0) begin
          mdrain = 1'b0;
          mhalted = 1'b1;
          mhalt = 1'b1;
        end
      end else if (q.size() < 2) begin
        q.push_back('{pc: mpc, ins: mem[mpc]});
        mdrain = mem[mpc] == HALT_INSTR;
        mpc = mpc + 8'd1;
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
